// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, fetches over req/ack,
// hands off to execute, then advances the PC by +4, a branch offset or a jump.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          FETCH_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        stall,
   input  logic        exec_done,
   input  logic        is_branch,
   input  logic [12:0] brc_incr,
   input  logic        is_jump,
   input  logic [31:0] jump_target,
   output logic [31:0] pc,
   output logic        retire,
   output logic        fault,
   output logic [1:0]  fault_cause
);

   localparam int CW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FETCH_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FETCH,
      S_WAIT,
      S_EXEC,
      S_UPDATE,
      S_HALT
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [31:0]   npc_q;
   logic [31:0]   next_pc;
   logic [31:0]   brc_ext;
   logic          go;
   logic          tmo;

   assign go      = ~stall & exec_done;
   assign tmo     = (cnt == CNT_MAX);
   assign brc_ext = {{19{brc_incr[12]}}, brc_incr};

   // Candidate next PC; jump wins over branch, everything wraps mod 2^32
   always_comb begin
      next_pc = pc + 32'd4;
      if (is_jump)
         next_pc = jump_target & ~32'h1;
      else if (is_branch)
         next_pc = pc + brc_ext;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_FETCH;
      else
         state <= state_nxt;
   end

   // Next-state logic; an ack on the timeout boundary still completes the fetch
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_FETCH:  state_nxt = S_WAIT;
         S_WAIT: begin
            if (imem_ack)
               state_nxt = S_EXEC;
            else if (tmo)
               state_nxt = S_HALT;
         end
         S_EXEC: begin
            if (go)
               state_nxt = S_UPDATE;
         end
         S_UPDATE: state_nxt = npc_q[1] ? S_HALT : S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_HALT;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      imem_req    = (state == S_WAIT);
      instr_valid = (state == S_EXEC);
      imem_addr   = pc;
   end

   // Datapath: PC, latched instruction, timeout counter, fault flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         instr       <= 32'h0;
         npc_q       <= 32'h0;
         cnt         <= '0;
         retire      <= 1'b0;
         fault       <= 1'b0;
         fault_cause <= 2'b00;
      end else begin
         retire <= 1'b0;
         unique case (state)
            S_FETCH: cnt <= '0;
            S_WAIT: begin
               if (imem_ack) begin
                  instr <= imem_rdata;
               end else if (tmo) begin
                  fault       <= 1'b1;
                  fault_cause <= 2'b10;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_EXEC: begin
               if (go)
                  npc_q <= next_pc;
            end
            S_UPDATE: begin
               if (npc_q[1]) begin
                  fault       <= 1'b1;
                  fault_cause <= 2'b01;
               end else begin
                  pc     <= npc_q;
                  retire <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential flow, branches, jumps,
// stall, fetch timeout, misaligned target, mid-fetch reset and PC wrap.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        stall = 1'b0;
   logic        exec_done = 1'b0;
   logic        is_branch = 1'b0;
   logic [12:0] brc_incr = 13'h0;
   logic        is_jump = 1'b0;
   logic [31:0] jump_target = 32'h0;
   logic [31:0] pc;
   logic        retire;
   logic        fault;
   logic [1:0]  fault_cause;

   int tests = 0;
   int failed = 0;

   pc_sequencer #(
      .RESET_PC      (32'h0000_0000),
      .FETCH_TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .stall       (stall),
      .exec_done   (exec_done),
      .is_branch   (is_branch),
      .brc_incr    (brc_incr),
      .is_jump     (is_jump),
      .jump_target (jump_target),
      .pc          (pc),
      .retire      (retire),
      .fault       (fault),
      .fault_cause (fault_cause)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for imem_req, then check the fetch address
   task automatic wait_req(input logic [31:0] exp_addr);
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", {31'h0, imem_req}, 32'h1);
      chk("imem_addr", imem_addr, exp_addr);
   endtask

   // Full instruction: fetch after wc wait cycles, execute, reach next FETCH/HALT
   task automatic fe(input logic [31:0] exp_pc, input logic [31:0] data,
                     input logic br, input logic [12:0] inc,
                     input logic jmp, input logic [31:0] tgt, input int wc);
      wait_req(exp_pc);
      repeat (wc) @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = data;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("instr_valid", {31'h0, instr_valid}, 32'h1);
      chk("instr", instr, data);
      is_branch   = br;
      brc_incr    = inc;
      is_jump     = jmp;
      jump_target = tgt;
      exec_done   = 1'b1;
      @(negedge clk);
      exec_done   = 1'b0;
      is_branch   = 1'b0;
      is_jump     = 1'b0;
      @(negedge clk);
   endtask

   task automatic ret(input logic [31:0] exp_pc);
      chk("retire", {31'h0, retire}, 32'h1);
      chk("pc", pc, exp_pc);
   endtask

   initial begin
      // reset values
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_retire", {31'h0, retire}, 32'h0);
      chk("rst_fault", {31'h0, fault}, 32'h0);
      chk("rst_cause", {30'h0, fault_cause}, 32'h0);
      chk("rst_instr", instr, 32'h0);
      reset = 1'b0;
      #1;
      chk("req_low_after_rst", {31'h0, imem_req}, 32'h0);

      // sequential flow
      fe(32'h0, 32'h1111_0013, 0, 13'h0, 0, 32'h0, 0);
      ret(32'h4);
      fe(32'h4, 32'h2222_0013, 0, 13'h0, 0, 32'h0, 0);
      ret(32'h8);
      fe(32'h8, 32'h3333_0013, 0, 13'h0, 0, 32'h0, 0);
      ret(32'hC);

      // jump to 0x100 then branches
      fe(32'hC, 32'h0000_006F, 0, 13'h0, 1, 32'h100, 0);
      ret(32'h100);
      fe(32'h100, 32'h0000_0063, 1, 13'h1FF8, 0, 32'h0, 0);
      ret(32'hF8);
      fe(32'hF8, 32'h0000_0063, 1, 13'h0008, 0, 32'h0, 0);
      ret(32'h100);
      fe(32'h100, 32'h0000_0063, 1, 13'h0004, 0, 32'h0, 0);
      ret(32'h104);

      // jump has priority over branch
      fe(32'h104, 32'h0000_0067, 1, 13'h1FF8, 1, 32'h40, 0);
      ret(32'h40);
      // jump target bit 0 cleared
      fe(32'h40, 32'h0000_006F, 0, 13'h0, 1, 32'h2001, 0);
      ret(32'h2000);

      // stall with exec_done held; ack outside WAIT ignored
      wait_req(32'h2000);
      imem_ack   = 1'b1;
      imem_rdata = 32'hCAFE_0013;
      @(negedge clk);
      stall      = 1'b1;
      exec_done  = 1'b1;
      is_branch  = 1'b1;
      brc_incr   = 13'h0100;
      imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_retire", {31'h0, retire}, 32'h0);
         chk("stall_valid", {31'h0, instr_valid}, 32'h1);
         chk("stall_instr", instr, 32'hCAFE_0013);
      end
      imem_ack  = 1'b0;
      stall     = 1'b0;
      is_branch = 1'b0;
      @(negedge clk);
      exec_done = 1'b0;
      chk("update_retire", {31'h0, retire}, 32'h0);
      @(negedge clk);
      ret(32'h2004);

      // ack on the last permitted wait cycle
      fe(32'h2004, 32'h4444_0013, 0, 13'h0, 0, 32'h0, 15);
      chk("late_ack_fault", {31'h0, fault}, 32'h0);
      ret(32'h2008);

      // wrap
      fe(32'h2008, 32'h0000_006F, 0, 13'h0, 1, 32'hFFFF_FFFC, 0);
      ret(32'hFFFF_FFFC);
      fe(32'hFFFF_FFFC, 32'h5555_0013, 0, 13'h0, 0, 32'h0, 0);
      ret(32'h0);

      // misaligned jump target
      fe(32'h0, 32'h0000_006F, 0, 13'h0, 1, 32'h40, 0);
      ret(32'h40);
      fe(32'h40, 32'h0000_006F, 0, 13'h0, 1, 32'h2002, 0);
      chk("mis_fault", {31'h0, fault}, 32'h1);
      chk("mis_cause", {30'h0, fault_cause}, 32'h1);
      chk("mis_pc", pc, 32'h40);
      chk("mis_retire", {31'h0, retire}, 32'h0);
      repeat (5) @(negedge clk);
      chk("halt_req", {31'h0, imem_req}, 32'h0);
      chk("halt_valid", {31'h0, instr_valid}, 32'h0);
      chk("halt_pc", pc, 32'h40);

      // reset clears fault
      reset = 1'b1;
      #1;
      chk("rst2_fault", {31'h0, fault}, 32'h0);
      chk("rst2_cause", {30'h0, fault_cause}, 32'h0);
      chk("rst2_pc", pc, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // fetch timeout
      wait_req(32'h0);
      repeat (15) @(negedge clk);
      chk("tmo_req_held", {31'h0, imem_req}, 32'h1);
      chk("tmo_no_fault_yet", {31'h0, fault}, 32'h0);
      @(negedge clk);
      chk("tmo_fault", {31'h0, fault}, 32'h1);
      chk("tmo_cause", {30'h0, fault_cause}, 32'h2);
      chk("tmo_req", {31'h0, imem_req}, 32'h0);
      chk("tmo_pc", pc, 32'h0);

      // reset mid-WAIT
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      fe(32'h0, 32'h6666_0013, 0, 13'h0, 0, 32'h0, 0);
      ret(32'h4);
      wait_req(32'h4);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_pc", pc, 32'h0);
      chk("midrst_req", {31'h0, imem_req}, 32'h0);
      chk("midrst_instr", instr, 32'h0);
      chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      wait_req(32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
